// File: rtl/df_pkg.sv
// Shared definitions for the sequential fractional multiplier: FSM states and default widths.
package df_pkg;

    localparam int DF_DW_DEFAULT = 8;
    localparam int DF_CW_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } df_state_t;

endpackage

// File: rtl/df_multiplier_seq.sv
// Sequential shift-add multiplier: out = upper DW bits of data * {coef, 1, 0...}.
// Optional build macro DF_MUL_ROUND_EN selects round-half-up instead of truncation.
module df_multiplier_seq
    import df_pkg::*;
#(
    parameter int DW = DF_DW_DEFAULT,
    parameter int CW = DF_CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] coef,
    input  logic [DW-1:0] data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out
);

    localparam int SHIFT0 = DW - CW - 1;
    localparam int CNTW   = $clog2(CW + 2);
    localparam logic [CNTW-1:0] LAST_COUNT = CNTW'(CW);
    localparam logic [2*DW-1:0] HALF_LSB = {{DW{1'b0}}, 1'b1, {(DW-1){1'b0}}};

    generate
        if (CW < 1 || CW > DW - 2) begin : g_bad_cfg
            $error("df_multiplier_seq: CW must satisfy 1 <= CW <= DW-2");
        end
    endgenerate

    df_state_t       state;
    df_state_t       state_nxt;
    logic [2*DW-1:0] acc;
    logic [2*DW-1:0] addend;
    logic [CW:0]     cbits;
    logic [CNTW-1:0] count;
    logic [2*DW-1:0] rounded;

    // The active coefficient bits {coef, 1} shift out LSB-first while the
    // addend (data aligned to the current bit weight) shifts left in step.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            addend <= '0;
            cbits  <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc    <= '0;
                        addend <= {{DW{1'b0}}, data} << SHIFT0;
                        cbits  <= {coef, 1'b1};
                        count  <= '0;
                    end
                end
                RUN: begin
                    if (cbits[0]) begin
                        acc <= acc + addend;
                    end
                    addend <= addend << 1;
                    cbits  <= cbits >> 1;
                    count  <= count + CNTW'(1);
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (count == LAST_COUNT) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The coefficient is below 1.0, so adding half an LSB cannot carry out of 2*DW bits.
    always_comb begin
`ifdef DF_MUL_ROUND_EN
        rounded = acc + HALF_LSB;
`else
        rounded = acc;
`endif
        out = out_valid ? rounded[2*DW-1:DW] : '0;
    end

endmodule

// File: tb/tb_df_multiplier_seq.sv
// Randomized self-checking bench for df_multiplier_seq against an arithmetic reference model.
module tb_df_multiplier_seq;

    localparam int DW = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] coef;
    logic [DW-1:0] data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    df_multiplier_seq #(.DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .coef      (coef),
        .data      (data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    // Reference: effective coefficient is a fraction of 2^DW with a hidden one below coef.
    function automatic int modelProduct(input int c, input int d);
        int ceff;
        int p;
        ceff = (c << (DW - CW)) | (1 << (DW - CW - 1));
        p    = d * ceff;
`ifdef DF_MUL_ROUND_EN
        p    = p + (1 << (DW - 1));
`endif
        return (p >> DW) & ((1 << DW) - 1);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full transaction; inputs are deliberately scrambled while busy.
    task automatic applyStimulus(input int coefv, input int datav, input int holdCycles,
                                 output logic [DW-1:0] result);
        int cycles;
        checkOutput("idle_ready", 32'(in_ready), 1);
        coef      = CW'(coefv);
        data      = DW'(datav);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick;
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            checkOutput("run_ready", 32'(in_ready), 0);
            checkOutput("run_out", 32'(out), 0);
            coef     = ~CW'(coefv);
            data     = ~DW'(datav);
            in_valid = 1'b1;
            tick;
            cycles++;
        end
        checkOutput("latency", 32'(cycles), CW + 1);
        result = out;
        checkOutput("result", 32'(out), 32'(modelProduct(coefv, datav)));
        for (int h = 0; h < holdCycles; h++) begin
            coef     = CW'($urandom);
            data     = DW'($urandom);
            in_valid = 1'b1;
            tick;
            checkOutput("hold_valid", 32'(out_valid), 1);
            checkOutput("hold_out", 32'(out), 32'(result));
            checkOutput("hold_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("release_valid", 32'(out_valid), 0);
        checkOutput("release_ready", 32'(in_ready), 1);
        checkOutput("release_out", 32'(out), 0);
    endtask

    task automatic waitDone(input int bound);
        int cycles;
        cycles = 0;
        while (!out_valid && cycles < bound) begin
            tick;
            cycles++;
        end
        checkOutput("reach_done", 32'(out_valid), 1);
    endtask

    initial begin
        logic [DW-1:0] res;
        int expTable[4];
`ifdef DF_MUL_ROUND_EN
        expTable = '{32'h20, 32'h60, 32'h9F, 32'hDF};
`else
        expTable = '{32'h1F, 32'h5F, 32'h9F, 32'hDF};
`endif
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        coef      = '0;
        data      = '0;
        tick;
        tick;
        rst = 1'b0;
        checkOutput("reset_ready", 32'(in_ready), 1);
        checkOutput("reset_valid", 32'(out_valid), 0);
        checkOutput("reset_out", 32'(out), 0);

        for (int c = 0; c < 4; c++) begin
            applyStimulus(c, 32'hFF, 0, res);
            checkOutput("directed_ff", 32'(res), 32'(expTable[c]));
        end

        // Data flips to 0x00 while busy; the latched 0xFF must be used.
        applyStimulus(3, 32'hFF, 1, res);
        checkOutput("isolation", 32'(res), 32'(expTable[3]));

        applyStimulus(1, 32'hA5, 5, res);

        for (int i = 0; i < 30; i++) begin
            applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 3)), res);
        end

        // Reset one cycle after accept.
        coef     = 2'd3;
        data     = 8'hFF;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checkOutput("rst_run_ready", 32'(in_ready), 1);
        checkOutput("rst_run_out", 32'(out), 0);
        checkOutput("rst_run_valid", 32'(out_valid), 0);
        for (int k = 0; k < 5; k++) begin
            tick;
            checkOutput("rst_run_quiet", 32'(out_valid), 0);
        end

        // Reset while holding a result.
        coef     = 2'd2;
        data     = 8'h3C;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        waitDone(20);
        rst       = 1'b1;
        out_ready = 1'b1;
        tick;
        rst       = 1'b0;
        out_ready = 1'b0;
        checkOutput("rst_done_valid", 32'(out_valid), 0);
        checkOutput("rst_done_ready", 32'(in_ready), 1);
        checkOutput("rst_done_out", 32'(out), 0);

        // Reset wins over a simultaneous offer.
        rst      = 1'b1;
        in_valid = 1'b1;
        tick;
        rst      = 1'b0;
        in_valid = 1'b0;
        checkOutput("rst_prio_ready", 32'(in_ready), 1);
        for (int k = 0; k < 5; k++) begin
            tick;
            checkOutput("rst_prio_quiet", 32'(out_valid), 0);
        end

        applyStimulus(2, 32'h81, 2, res);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/df_multiplier_seq.md
DF_MULTIPLIER_SEQ -- requirements
Module: df_multiplier_seq

Interface
REQ-001 SHALL have parameter DW, default 8, meaning data and output width in bits.
REQ-002 SHALL have parameter CW, default 2, meaning coefficient width in bits; legal range is 1 <= CW <= DW-2.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operand pair offered.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-007 SHALL have port coef  input  CW  coefficient code.
REQ-008 SHALL have port data  input  DW  unsigned sample.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port out  output  DW  unsigned product result.

Function
REQ-012 SHALL form the effective coefficient c (DW bits) as {coef, 1'b1, (DW-CW-1) zero bits}, i.e. an unsigned fraction of 2^DW.
REQ-013 SHALL compute out = bits [2DW-1:DW] of the 2DW-bit product data*c; truncation is the default.
REQ-014 SHALL implement the product iteratively by shift-add with a 2DW-bit accumulator, one bit of c per RUN cycle, starting at bit DW-CW-1 and ending at bit DW-1.
REQ-015 SHALL use FSM states IDLE, RUN and DONE.
REQ-016 SHALL, in IDLE, drive in_ready=1; when in_valid=1 the edge latches coef and data, clears the accumulator, sets the bit counter to 0 and moves to RUN.
REQ-017 SHALL, in RUN, drive in_ready=0; each edge adds data<<(DW-CW-1+count) when the corresponding bit of c is set; after CW+1 RUN edges the state moves to DONE.
REQ-018 SHALL, in DONE, drive out_valid=1 with out stable; the edge with out_ready=1 returns the FSM to IDLE, and out_valid holds otherwise.
REQ-019 SHALL assert out_valid exactly CW+1 rising edges after the accepting edge; the throughput is one result per CW+3 cycles with out_ready held high.
REQ-020 SHALL ignore coef, data and in_valid changes while in RUN or DONE; the latched values are used.
REQ-021 SHALL drive out=0 whenever out_valid=0.
REQ-022 SHALL never overflow: the upper DW bits, including the rounded case, stay <= 2^DW-1 for all inputs.

Reset
REQ-023 SHALL, with rst=1 on an edge, force IDLE, accumulator=0, counter=0, out_valid=0, out=0 and in_ready=1 from the next cycle.
REQ-024 SHALL abandon any operation in progress when reset is asserted mid-RUN or mid-DONE, with no result emitted.
REQ-025 SHALL give rst priority over an in_valid or out_ready event on the same edge.

Configuration
REQ-026 SHALL, with macro DF_MUL_ROUND_EN defined, add 2^(DW-1) to the accumulator before taking bits [2DW-1:DW] (round-half-up); without it the result is truncated; latency is identical in both builds.

Structure
REQ-027 SHALL place the FSM state enum (IDLE/RUN/DONE) and the default DW/CW constants in shared package df_pkg.
REQ-028 SHALL be implemented as a single module; no sub-module is needed.
REQ-029 SHALL reject illegal CW/DW combinations at elaboration.

Verification
REQ-030 SHALL verify truncation with DW=8, CW=2, data=0xFF and coef=0,1,2,3 -> out=0x1F,0x5F,0x9F,0xDF.
REQ-031 SHALL verify the DF_MUL_ROUND_EN build with the same stimulus as REQ-030 -> out=0x20,0x60,0x9F,0xDF.
REQ-032 SHALL verify latency: accept at edge N -> out_valid high after edge N+3 (CW=2), in_ready low from N+1 until return to IDLE.
REQ-033 SHALL verify backpressure: out_ready held 0 for 5 cycles -> out_valid and out stable, no new input accepted, and release -> IDLE on the next edge.
REQ-034 SHALL verify reset mid-RUN: rst pulse one cycle after accept -> out_valid never rises, in_ready=1 and out=0 the next cycle.
REQ-035 SHALL verify input isolation: data changed 0xFF->0x00 during RUN with coef=3 -> out=0xDF.
